// File: rtl/mac_accum_seq.sv
// Streaming fixed-point multiply-accumulate unit.
// Accumulates a*b over a vector, adds a bias, and emits one floor-reduced W-bit result per vector.
module mac_accum_seq #(
  parameter  int INT_PART   = 3,
  parameter  int FRACT_PART = 2,
  parameter  int MAX_LEN    = 16,
  parameter  int SATURATE   = 1,
  localparam int W          = INT_PART + FRACT_PART,
  localparam int L          = $clog2(MAX_LEN) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_ovf,
  output logic [L-1:0]        out_len
);

  localparam int A = 2*W + L + 1;
  localparam logic signed [A-1:0] R_MAX = A'((1 << (W-1)) - 1);
  localparam logic signed [A-1:0] R_MIN = A'(-(1 << (W-1)));

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_t;

  state_t                state_q, state_d;
  logic                  first_q;
  logic                  s1_valid_q, s1_first_q, s1_last_q;
  logic signed [2*W-1:0] p_q;
  logic signed [W-1:0]   s1_bias_q;
  logic signed [A-1:0]   acc_q;
  logic [L-1:0]          len_q;
  logic                  s2_done_q;
  logic signed [W-1:0]   out_data_q;
  logic                  out_ovf_q;
  logic [L-1:0]          out_len_q;

  logic                  beat, load_out;
  logic signed [A-1:0]   bias_ext, p_ext, r_full;
  logic                  r_ovf;
  logic signed [W-1:0]   r_out;

  // in_ready is gated by rst so nothing is offered while reset is held
  assign in_ready = (state_q == ST_ACCUM) && !rst;
  assign beat     = in_valid && in_ready;
  assign load_out = (state_q == ST_DRAIN) && s2_done_q;

  assign bias_ext = A'(s1_bias_q) <<< FRACT_PART;
  assign p_ext    = A'(p_q);
  assign r_full   = acc_q >>> FRACT_PART;
  assign r_ovf    = (r_full > R_MAX) || (r_full < R_MIN);

  generate
    if (SATURATE != 0) begin : g_sat
      assign r_out = (r_full > R_MAX) ? W'(R_MAX) :
                     (r_full < R_MIN) ? W'(R_MIN) : r_full[W-1:0];
    end else begin : g_wrap
      // wrap keeps the true sign so downstream never sees a flipped polarity
      assign r_out = {acc_q[A-1], r_full[W-2:0]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (beat && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (s2_done_q)       state_d = ST_HOLD;
      ST_HOLD:  if (out_ready)       state_d = ST_ACCUM;
      default:                       state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q    <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      p_q        <= '0;
      s1_bias_q  <= '0;
      acc_q      <= '0;
      len_q      <= '0;
      s2_done_q  <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_len_q  <= '0;
    end else begin
      s1_valid_q <= beat;
      if (beat) begin
        p_q        <= (2*W)'(a) * (2*W)'(b);
        s1_first_q <= first_q;
        s1_last_q  <= in_last;
        s1_bias_q  <= bias;
        first_q    <= in_last;
      end

      s2_done_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        if (s1_first_q) begin
          acc_q <= bias_ext + p_ext;
          len_q <= L'(1);
        end else begin
          acc_q <= acc_q + p_ext;
          if (len_q != L'(MAX_LEN)) len_q <= len_q + L'(1);
        end
      end

      if (load_out) begin
        out_data_q <= r_out;
        out_ovf_q  <= r_ovf;
        out_len_q  <= len_q;
      end
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_len   = out_len_q;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Directed bench for mac_accum_seq: a saturating and a wrapping instance share one stimulus stream.
module tb_mac_accum_seq;
  localparam int W = 5;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0, bias = '0;
  logic         in_ready, out_valid, out_ovf;
  logic [W-1:0] out_data;
  logic [L-1:0] out_len;
  logic         in_ready_w, out_valid_w, out_ovf_w;
  logic [W-1:0] out_data_w;
  logic [L-1:0] out_len_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_accum_seq #(.INT_PART(3), .FRACT_PART(2), .MAX_LEN(16), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a(a), .b(b), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_len(out_len)
  );

  mac_accum_seq #(.INT_PART(3), .FRACT_PART(2), .MAX_LEN(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
    .a(a), .b(b), .bias(bias), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_ovf(out_ovf_w), .out_len(out_len_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input int av, input int bv, input int biasv, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    a = W'(av);
    b = W'(bv);
    bias = W'(biasv);
    in_last = last;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_wait: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_wait: out_valid=%0b after %0d cycles, required 1", out_valid, cyc);
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_vdrop"}, out_valid, 1'b0);
    check_eq({tag, "_rdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    #2;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_ready", in_ready, 1'b0);
    check_eq("rst_data", out_data, 5'd0);
    check_eq("rst_ovf", out_ovf, 1'b0);
    check_eq("rst_len", out_len, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single beat: 1.5*2.0 + 0.5 = 3.5
    send_beat(6, 8, 2, 1'b1);
    check_eq("t1_rdy_low", in_ready, 1'b0);
    wait_result(cyc);
    check_eq("t1_latency", cyc, 2);
    check_eq("t1_data", out_data, 5'd14);
    check_eq("t1_ovf", out_ovf, 1'b0);
    check_eq("t1_len", out_len, 5'd1);
    take_result("t1");

    // three beats of 1.0*1.0, bias -1.0 -> 2.0
    send_beat(4, 4, -4, 1'b0);
    send_beat(4, 4, -4, 1'b0);
    send_beat(4, 4, -4, 1'b1);
    check_eq("t2_rdy_low", in_ready, 1'b0);
    wait_result(cyc);
    check_eq("t2_rdy_hold", in_ready, 1'b0);
    check_eq("t2_data", out_data, 5'd8);
    check_eq("t2_len", out_len, 5'd3);
    take_result("t2");

    // overflow: r=56 saturates to 15, wraps to {0,r[3:0]}=8
    send_beat(15, 15, 0, 1'b1);
    wait_result(cyc);
    check_eq("t3_sat_data", out_data, 5'd15);
    check_eq("t3_sat_ovf", out_ovf, 1'b1);
    check_eq("t3_wrap_data", out_data_w, 5'b01000);
    check_eq("t3_wrap_ovf", out_ovf_w, 1'b1);
    take_result("t3");

    // negative overflow: r=-60 saturates to -16, wraps to {1,0100}
    send_beat(-16, 15, 0, 1'b1);
    wait_result(cyc);
    check_eq("t3n_sat_data", out_data, 5'b10000);
    check_eq("t3n_sat_ovf", out_ovf, 1'b1);
    check_eq("t3n_wrap_data", out_data_w, 5'b10100);
    take_result("t3n");

    // floor truncation
    send_beat(1, 1, 0, 1'b1);
    wait_result(cyc);
    check_eq("t4_pos_floor", out_data, 5'd0);
    check_eq("t4_pos_ovf", out_ovf, 1'b0);
    take_result("t4p");
    send_beat(-1, 1, 0, 1'b1);
    wait_result(cyc);
    check_eq("t4_neg_floor", out_data, 5'b11111);
    check_eq("t4_neg_ovf", out_ovf, 1'b0);
    take_result("t4n");

    // backpressure: 0.5*0.5 + 0.25 = 0.5, held while beats are offered
    send_beat(2, 2, 1, 1'b1);
    wait_result(cyc);
    in_valid = 1'b1;
    a = 5'd7;
    b = 5'd7;
    bias = 5'd7;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("t5_hold%0d_data", i), out_data, 5'd2);
      check_eq($sformatf("t5_hold%0d_len", i), out_len, 5'd1);
      check_eq($sformatf("t5_hold%0d_rdy", i), in_ready, 1'b0);
      check_eq($sformatf("t5_hold%0d_vld", i), out_valid, 1'b1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    take_result("t5");
    send_beat(4, 4, 3, 1'b1);
    wait_result(cyc);
    check_eq("t5_next_data", out_data, 5'd7);
    check_eq("t5_next_len", out_len, 5'd1);
    take_result("t5n");

    // maximum length vector
    for (int i = 0; i < 16; i++) send_beat(0, 0, 1, (i == 15));
    wait_result(cyc);
    check_eq("t6_data", out_data, 5'd1);
    check_eq("t6_len", out_len, 5'd16);
    take_result("t6");

    // reset mid-vector
    send_beat(4, 4, 5, 1'b0);
    send_beat(4, 4, 5, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("t7_rst_valid", out_valid, 1'b0);
    check_eq("t7_rst_ready", in_ready, 1'b0);
    check_eq("t7_rst_data", out_data, 5'd0);
    check_eq("t7_rst_len", out_len, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_beat(4, 4, 0, 1'b1);
    wait_result(cyc);
    check_eq("t7_data", out_data, 5'd4);
    check_eq("t7_len", out_len, 5'd1);
    take_result("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
